// File: rtl/clock_cmd_sequencer.sv
// Command front-end for digital_clock: validates mode commands, drives set/alarm/timer inputs,
// acknowledges buzzers and formats the 12-hour display. Optional snooze: define CLOCK_SNOOZE_EN.
module clock_cmd_sequencer #(
    parameter int DEFAULT_YEAR = 2020,
    parameter int IDLE_LIMIT   = 5,
    parameter int SNOOZE_MIN   = 5
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [2:0]  i_cmd_mode,
    input  logic [4:0]  i_cmd_hour,
    input  logic [5:0]  i_cmd_min,
    input  logic [5:0]  i_cmd_sec,
    input  logic [4:0]  i_cmd_day,
    input  logic [3:0]  i_cmd_month,
    input  logic [11:0] i_cmd_year,
    output logic        o_cmd_err,
    output logic [4:0]  o_set_hour,
    output logic [5:0]  o_set_min,
    output logic [5:0]  o_set_sec,
    output logic [4:0]  o_set_day,
    output logic [3:0]  o_set_month,
    output logic [11:0] o_set_year,
    output logic        o_load_time,
    output logic [4:0]  o_alarm_hour,
    output logic [5:0]  o_alarm_min,
    output logic [5:0]  o_alarm_sec,
    output logic        o_alarm_enable,
    output logic [5:0]  o_timer_min,
    output logic [5:0]  o_timer_sec,
    output logic        o_timer_start,
    input  logic        i_alarm_buzzer,
    input  logic        i_timer_buzzer,
    input  logic [4:0]  i_hour,
    output logic        o_alarm_event,
    output logic        o_timer_event,
    output logic        o_display_12h,
    output logic [3:0]  o_disp_hour12,
    output logic        o_disp_pm,
    output logic        o_sim_done,
    input  logic        i_snooze
);

    localparam int QW = $clog2(IDLE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_cmd_err;
    logic [4:0]    r_set_hour;
    logic [5:0]    r_set_min;
    logic [5:0]    r_set_sec;
    logic [4:0]    r_set_day;
    logic [3:0]    r_set_month;
    logic [11:0]   r_set_year;
    logic [4:0]    r_alarm_hour;
    logic [5:0]    r_alarm_min;
    logic [5:0]    r_alarm_sec;
    logic          r_alarm_enable;
    logic [5:0]    r_timer_min;
    logic [5:0]    r_timer_sec;
    logic          r_timer_start;
    logic          r_alarm_prev;
    logic          r_timer_prev;
    logic          r_alarm_event;
    logic          r_timer_event;
    logic          r_display_12h;
    logic [3:0]    r_disp_hour12;
    logic          r_disp_pm;
    logic [QW-1:0] r_quiet;

    logic w_idle;
    logic w_xfer;
    logic w_time_ok;
    logic w_date_ok;
    logic w_cmd_ok;
    logic w_accept;
    logic w_do_set;
    logic w_do_alarm;
    logic w_do_timer;
    logic w_alarm_fire;
    logic w_timer_fire;

    assign w_idle       = (r_state == S_IDLE);
    assign w_xfer       = i_cmd_valid && w_idle;
    assign w_time_ok    = (i_cmd_hour <= 5'd23) && (i_cmd_min <= 6'd59) && (i_cmd_sec <= 6'd59);
    assign w_date_ok    = (i_cmd_day != 5'd0) && (i_cmd_month != 4'd0) && (i_cmd_month <= 4'd12);
    assign w_accept     = w_xfer && w_cmd_ok;
    assign w_do_set     = w_accept && (i_cmd_mode == 3'd3);
    assign w_do_alarm   = w_accept && (i_cmd_mode == 3'd4);
    assign w_do_timer   = w_accept && (i_cmd_mode == 3'd5);
    assign w_alarm_fire = i_alarm_buzzer && !r_alarm_prev && r_alarm_enable;
    assign w_timer_fire = i_timer_buzzer && !r_timer_prev && r_timer_start;

    // A zero-length timer is meaningless, so mode 5 also rejects 0:00.
    always_comb begin
        w_cmd_ok = 1'b0;
        case (i_cmd_mode)
            3'd1, 3'd2: w_cmd_ok = 1'b1;
            3'd3:       w_cmd_ok = w_time_ok && w_date_ok;
            3'd4:       w_cmd_ok = w_time_ok;
            3'd5:       w_cmd_ok = (i_cmd_min <= 6'd59) && (i_cmd_sec <= 6'd59) &&
                                   ((i_cmd_min != 6'd0) || (i_cmd_sec != 6'd0));
            default:    w_cmd_ok = 1'b0;
        endcase
    end

`ifdef CLOCK_SNOOZE_EN
    logic       r_snooze_armed;
    logic       w_snooze_go;
    logic [6:0] w_snz_sum;
    logic       w_snz_wrap;
    logic [5:0] w_snz_min;
    logic [4:0] w_snz_hour;

    assign w_snooze_go = i_snooze && w_idle && !w_xfer && r_snooze_armed && !r_alarm_enable;
    assign w_snz_sum   = {1'b0, r_alarm_min} + 7'(SNOOZE_MIN);
    assign w_snz_wrap  = (w_snz_sum >= 7'd60);
    assign w_snz_min   = w_snz_wrap ? 6'(w_snz_sum - 7'd60) : w_snz_sum[5:0];
    assign w_snz_hour  = !w_snz_wrap ? r_alarm_hour :
                         (r_alarm_hour >= 5'd23) ? 5'd0 : r_alarm_hour + 5'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset)           r_snooze_armed <= 1'b0;
        else if (w_do_alarm)   r_snooze_armed <= 1'b0;
        else if (w_alarm_fire) r_snooze_armed <= 1'b1;
        else if (w_snooze_go)  r_snooze_armed <= 1'b0;
    end
`else
    logic w_unused_snooze;
    assign w_unused_snooze = i_snooze;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_load_time = 1'b0;
        case (r_state)
            S_IDLE:   if (w_do_set) w_next = S_LOAD;
            S_LOAD: begin
                o_load_time = 1'b1;
                w_next      = S_SETTLE;
            end
            S_SETTLE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cmd_err      <= 1'b0;
            r_set_hour     <= 5'd0;
            r_set_min      <= 6'd0;
            r_set_sec      <= 6'd0;
            r_set_day      <= 5'd1;
            r_set_month    <= 4'd1;
            r_set_year     <= 12'(DEFAULT_YEAR);
            r_alarm_hour   <= 5'd0;
            r_alarm_min    <= 6'd0;
            r_alarm_sec    <= 6'd0;
            r_alarm_enable <= 1'b0;
            r_timer_min    <= 6'd0;
            r_timer_sec    <= 6'd0;
            r_timer_start  <= 1'b0;
            r_alarm_prev   <= 1'b0;
            r_timer_prev   <= 1'b0;
            r_alarm_event  <= 1'b0;
            r_timer_event  <= 1'b0;
            r_display_12h  <= 1'b0;
            r_quiet        <= '0;
        end else begin
            r_cmd_err     <= w_xfer && !w_cmd_ok;
            r_alarm_prev  <= i_alarm_buzzer;
            r_timer_prev  <= i_timer_buzzer;
            r_alarm_event <= w_alarm_fire;
            r_timer_event <= w_timer_fire;

            if (w_accept && (i_cmd_mode == 3'd1)) r_display_12h <= 1'b1;
            if (w_accept && (i_cmd_mode == 3'd2)) r_display_12h <= 1'b0;

            if (w_do_set) begin
                r_set_hour  <= i_cmd_hour;
                r_set_min   <= i_cmd_min;
                r_set_sec   <= i_cmd_sec;
                r_set_day   <= i_cmd_day;
                r_set_month <= i_cmd_month;
                r_set_year  <= i_cmd_year;
            end

            // A new command beats a simultaneous buzzer acknowledge.
            if (w_do_alarm) begin
                r_alarm_hour   <= i_cmd_hour;
                r_alarm_min    <= i_cmd_min;
                r_alarm_sec    <= i_cmd_sec;
                r_alarm_enable <= 1'b1;
            end else if (w_alarm_fire) begin
                r_alarm_enable <= 1'b0;
`ifdef CLOCK_SNOOZE_EN
            end else if (w_snooze_go) begin
                r_alarm_hour   <= w_snz_hour;
                r_alarm_min    <= w_snz_min;
                r_alarm_enable <= 1'b1;
`endif
            end

            if (w_do_timer) begin
                r_timer_min   <= i_cmd_min;
                r_timer_sec   <= i_cmd_sec;
                r_timer_start <= 1'b1;
            end else if (w_timer_fire) begin
                r_timer_start <= 1'b0;
            end

            if (w_xfer || r_alarm_event || r_timer_event || r_alarm_enable || r_timer_start)
                r_quiet <= '0;
            else if (r_quiet != QW'(IDLE_LIMIT))
                r_quiet <= r_quiet + QW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_disp_hour12 <= 4'd12;
            r_disp_pm     <= 1'b0;
        end else if (i_hour == 5'd0) begin
            r_disp_hour12 <= 4'd12;
            r_disp_pm     <= 1'b0;
        end else if (i_hour < 5'd12) begin
            r_disp_hour12 <= i_hour[3:0];
            r_disp_pm     <= 1'b0;
        end else if (i_hour == 5'd12) begin
            r_disp_hour12 <= 4'd12;
            r_disp_pm     <= 1'b1;
        end else begin
            r_disp_hour12 <= 4'(i_hour - 5'd12);
            r_disp_pm     <= 1'b1;
        end
    end

    assign o_cmd_ready    = w_idle;
    assign o_cmd_err      = r_cmd_err;
    assign o_set_hour     = r_set_hour;
    assign o_set_min      = r_set_min;
    assign o_set_sec      = r_set_sec;
    assign o_set_day      = r_set_day;
    assign o_set_month    = r_set_month;
    assign o_set_year     = r_set_year;
    assign o_alarm_hour   = r_alarm_hour;
    assign o_alarm_min    = r_alarm_min;
    assign o_alarm_sec    = r_alarm_sec;
    assign o_alarm_enable = r_alarm_enable;
    assign o_timer_min    = r_timer_min;
    assign o_timer_sec    = r_timer_sec;
    assign o_timer_start  = r_timer_start;
    assign o_alarm_event  = r_alarm_event;
    assign o_timer_event  = r_timer_event;
    assign o_display_12h  = r_display_12h;
    assign o_disp_hour12  = r_disp_hour12;
    assign o_disp_pm      = r_disp_pm;
    assign o_sim_done     = (r_quiet == QW'(IDLE_LIMIT)) && !r_alarm_enable && !r_timer_start;

endmodule
